memory_reader: RTL and testbench
================================

# memory_reader

Streams a contiguous run of 32-bit instruction words out of the 1024-word instruction RAM, i.e. the consumer side of the instruction memory load path. Given a start address and word count, it drives the RAM's synchronous read port, absorbs the one-cycle read latency in a 2-entry skid buffer, and delivers words in address order on a valid/ready stream. It sits between the instruction RAM and the decode/dispatch logic.

## Interface
- `ADDR_W`, 10, RAM word-address width (1024 words)
- `DATA_W`, 32, instruction word width
- `clk` in 1: single clock, all state changes on posedge
- `reset` in 1: synchronous, active-high
- `start` in 1: request pulse, sampled only in IDLE
- `start_addr` in ADDR_W: first word address
- `count` in ADDR_W+1: words to read, 0..1024
- `mem_rd_en` out 1: RAM read strobe
- `mem_rd_addr` out ADDR_W: RAM read address
- `mem_rd_data` in DATA_W: RAM data, valid the cycle after `mem_rd_en`
- `out_valid` out 1: `out_data` holds a word
- `out_data` out DATA_W: word at head of skid buffer
- `out_ready` in 1: consumer accepts; transfer when `out_valid && out_ready` at posedge
- `busy` out 1: high from start acceptance until `done`
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 latches `start_addr` into addr register and `count` into remaining. count=0 → next state DRAIN (no reads, done follows). Else → RUN.
- RUN: issue a read (`mem_rd_en`=1, `mem_rd_addr`=addr) when remaining>0 and credit available; on issue addr←addr+1 (mod 1024, 1023 wraps to 0), remaining←remaining−1. remaining reaches 0 → DRAIN.
- Credit: issue permitted when buffer_count + inflight − pop < 2, where pop = handshake this cycle. Guarantees buffer never overflows; sustains 1 word/cycle with `out_ready` held high.
- Read data captured into the buffer on the posedge after issue, unconditionally (credit guarantees room).
- DRAIN: when buffer empty and no read in flight → `done`=1 for one cycle, `busy`=0, → IDLE.
- `start` in RUN/DRAIN ignored; operands not re-latched.
- Words emerge strictly in issue order; `out_data` stable while `out_valid && !out_ready`.
- `mem_rd_en`, `mem_rd_addr` are combinational from state/registers; `out_valid`, `out_data`, `busy`, `done` from registers only.

## Timing
- Reset: state IDLE; `mem_rd_en`=0, `mem_rd_addr`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; buffer emptied; in-flight read discarded (its returning data ignored).
- `reset` mid-run aborts with no `done` pulse; next cycle is IDLE.
- Start accepted at edge E0: `busy`=1 and first `mem_rd_en`=1 in cycle after E0; first `out_valid`=1 in cycle after E2 (start-to-data latency 2).
- `out_ready` held 1: N words take N cycles of `out_valid`; `done` in cycle after the edge accepting the last word.
- count=0: `done` in cycle after E1, no `mem_rd_en`.
- Backpressure: at most 2 reads outstanding beyond the consumer; `mem_rd_en` drops within one cycle of `out_ready` falling.
- `done` and a new `start` same cycle: `start` ignored (state not IDLE).

## Configuration
- `MEMORY_READER_WCOUNT_EN` defined: adds output `words_out` (ADDR_W+1 bits), cleared on reset and on start acceptance, incremented on each output handshake; holds final value after `done`.
- Undefined: port absent, no counter logic; all other behaviour identical.

## Test plan
- Basic: RAM[i]=0xA000_0000+i; start_addr=5, count=3, `out_ready`=1 → out_data 0xA000_0005, 6, 7 on consecutive cycles, first `out_valid` 2 cycles after start edge, `done` once.
- Wrap: start_addr=1022, count=4 → addresses 1022, 1023, 0, 1 on `mem_rd_addr`; data in that order.
- Backpressure: count=6, `out_ready` toggled 1,0,0,1,0,1... → all 6 words delivered once, in order, `out_data` stable while stalled, never >2 reads outstanding.
- Zero/full: count=0 → no `mem_rd_en`, `done` one cycle after start edge; count=1024, start_addr=0 → 1024 words, last 0xA000_03FF; with macro, `words_out`=1024.
- Ignore/abort: `start` pulsed mid-run with different operands → ignored; `reset` asserted after 2 of 5 words → all outputs 0 next cycle, no `done`, new start then behaves as basic case.

Source files
------------

// File: rtl/memory_reader.sv
// Streams a contiguous run of words from the synchronous-read instruction RAM onto a valid/ready stream.
// Optional words_out handshake counter is enabled by defining MEMORY_READER_WCOUNT_EN.
module memory_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
`ifdef MEMORY_READER_WCOUNT_EN
  output logic [ADDR_W:0]   words_out,
`endif
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inflight;
  logic [1:0]        r_buf_cnt;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic              r_busy;
  logic              r_done;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_credit;
  logic              w_issue;
  logic [1:0]        w_cnt_next;
  logic              w_wr_slot1;

  // Occupancy counts the word still in the RAM pipeline, so a read is only
  // issued when its data is guaranteed a free buffer slot on arrival.
  assign w_pop      = (r_buf_cnt != 2'd0) && out_ready;
  assign w_push     = r_inflight;
  assign w_occ      = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
  assign w_credit   = (w_occ - {2'b00, w_pop}) < 3'd2;
  assign w_issue    = (r_state == S_RUN) && (r_remaining != '0) && w_credit;
  assign w_cnt_next = r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_wr_slot1 = (r_buf_cnt - {1'b0, w_pop}) != 2'd0;

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_addr;
  assign out_valid   = (r_buf_cnt != 2'd0);
  assign out_data    = r_buf0;
  assign busy        = r_busy;
  assign done        = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_buf_cnt   <= 2'd0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_buf_cnt  <= w_cnt_next;
      r_done     <= 1'b0;

      // Head is always r_buf0; a pop shifts, and the arriving word lands in the
      // first slot left free after that shift.
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (w_push) begin
        if (w_wr_slot1) begin
          r_buf1 <= mem_rd_data;
        end else begin
          r_buf0 <= mem_rd_data;
        end
      end

      if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= start_addr;
            r_remaining <= count;
            r_busy      <= 1'b1;
            r_state     <= (count == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue && (r_remaining == (ADDR_W+1)'(1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Stay out of IDLE during the done cycle so a coincident start is dropped.
          if (r_done) begin
            r_state <= S_IDLE;
          end else if (w_cnt_next == 2'd0) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEMORY_READER_WCOUNT_EN
  logic [ADDR_W:0] r_words_out;

  assign words_out = r_words_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_words_out <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_words_out <= '0;
    end else if (w_pop) begin
      r_words_out <= r_words_out + (ADDR_W+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: RAM model with one-cycle read latency, stream checks per cycle.
module tb_memory_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef MEMORY_READER_WCOUNT_EN
  logic [ADDR_W:0]   words_out;
`endif

  logic [DATA_W-1:0] ram [1024];
  int n_cmp = 0;
  int n_bad = 0;
  bit [5:0] pat = 6'b101001;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  memory_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .count(count),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
`ifdef MEMORY_READER_WCOUNT_EN
    .words_out(words_out),
`endif
    .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int a, input int c);
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    count      = (ADDR_W+1)'(c);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready follows 1,0,0,1,0,1 repeating.
  task automatic run_stream(input int a, input int c, input int mode, input bit inject);
    int cyc = 0;
    int issued = 0;
    int accepted = 0;
    int first_valid = -1;
    int first_rd = -1;
    int done_cyc = -1;
    int budget;
    bit seen_done = 0;
    bit prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;
    budget = c * 4 + 20;
    out_ready = 1'b1;
    do_start(a, c);
    while (!seen_done && cyc < budget) begin
      out_ready = (mode == 0) ? 1'b1 : pat[cyc % 6];
      if (inject) begin
        start      = (cyc == 3);
        start_addr = ADDR_W'(a + 100);
        count      = (ADDR_W+1)'(2);
      end
      #1;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        check("busy_in_done", busy, 0);
        check("valid_in_done", out_valid, 0);
      end else begin
        if (mem_rd_en) begin
          if (first_rd < 0) first_rd = cyc;
          check("rd_addr", mem_rd_addr, (a + issued) % 1024);
          issued++;
        end
        if (out_valid) begin
          if (first_valid < 0) first_valid = cyc;
          if (prev_stall) check("stall_hold", out_data, prev_data);
          if (out_ready) begin
            check("out_data", out_data, 32'hA000_0000 + (a + accepted) % 1024);
            accepted++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        check("outstanding_le2", (issued - accepted) <= 2, 1);
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    check("words_delivered", accepted, c);
    check("reads_issued", issued, c);
    if (c > 0) begin
      check("first_rd_cycle", first_rd, 0);
      check("first_valid_cycle", first_valid, 2);
    end
    if (mode == 0) check("done_cycle", done_cyc, (c == 0) ? 1 : c + 2);
`ifdef MEMORY_READER_WCOUNT_EN
    check("words_out", words_out, c);
`endif
    $display("stream addr=%0d count=%0d mode=%0d: words=%0d reads=%0d done_cycle=%0d",
             a, c, mode, accepted, issued, done_cyc);
    // A start coinciding with done must be dropped.
    start      = 1'b1;
    start_addr = '0;
    count      = '0;
    tick();
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + i;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef MEMORY_READER_WCOUNT_EN
    check("rst_words_out", words_out, 0);
`endif
    reset = 1'b0;
    tick();

    run_stream(5, 3, 0, 0);
    run_stream(1022, 4, 0, 0);
    run_stream(40, 6, 1, 0);
    run_stream(300, 0, 0, 0);
    run_stream(200, 5, 0, 1);

    // Abort after two of five words.
    out_ready = 1'b1;
    do_start(5, 5);
    tick();
    tick();
    tick();
    tick();
    check("abort_pre_valid", out_valid, 1);
    check("abort_pre_data", out_data, 32'hA000_0007);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_rd_addr", mem_rd_addr, 0);
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_abort_valid", out_valid, 0);
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    $display("abort after 2 of 5 words: outputs cleared");
    run_stream(5, 3, 0, 0);

    run_stream(0, 1024, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
